// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_WIDTH = 16;
  localparam int CNT_W     = $clog2(MUL_WIDTH);

  // Iteration counter width for any operand width, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier and the
// iteration counter, driven by load/step strobes from the sequencer.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic [2*WIDTH-1:0] acc_sum_o,
  output logic               mult_zero_o,
  output logic               last_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] addend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    addend  = mult_q[0] ? mcand_q : '0;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, op_b_i};
      mult_d  = op_a_i;
      cnt_d   = '0;
    end else if (step_i) begin
      acc_d   = acc_q + addend;
      mcand_d = mcand_q << 1;
      mult_d  = mult_q >> 1;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Sum of the current iteration, so the sequencer can latch the product on
  // the same edge that leaves RUN.
  assign acc_sum_o   = acc_q + addend;
  assign mult_zero_o = (mult_q >> 1) == '0;
  assign last_o      = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mul_sequencer.sv
// Multiply controller for EX: IDLE/RUN/DONE FSM, stall decode and product hold.
// Define MUL_EARLY_EXIT_EN to leave RUN as soon as the remaining multiplier is zero.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  mul_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] acc_sum;
  logic               mult_zero;
  logic               last;
  logic               run_exit;
  logic               load;
  logic               step;

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .step_i     (step),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .acc_sum_o  (acc_sum),
    .mult_zero_o(mult_zero),
    .last_o     (last)
  );

`ifdef MUL_EARLY_EXIT_EN
  assign run_exit = last | mult_zero;
`else
  logic unused_mult_zero;
  assign unused_mult_zero = mult_zero;
  assign run_exit         = last;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (run_exit) begin
          state_d   = DONE;
          product_d = acc_sum;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush abandons the multiply without touching the held product.
    if (flush_i) begin
      state_d   = IDLE;
      product_d = product_q;
    end
  end

  always_comb begin
    load      = (state_q == IDLE);
    step      = (state_q == RUN);
    busy_o    = (state_q == RUN);
    done_o    = (state_q == DONE) && !flush_i;
    stall_o   = rst_ni && (((state_q == IDLE) && start_i && !flush_i) || (state_q == RUN));
    product_o = product_q;
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer; expected latencies follow MUL_EARLY_EXIT_EN.
module tb_mul_sequencer;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        flush;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checkCount = 0;
  int errorCount = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_ZERO = 2;
  localparam int LAT_3    = 3;
  localparam int LAT_2    = 3;
  localparam int LAT_5    = 4;
`else
  localparam int LAT_ZERO = 17;
  localparam int LAT_3    = 17;
  localparam int LAT_2    = 17;
  localparam int LAT_5    = 17;
`endif

  mul_sequencer #(.WIDTH(16)) dut (
    .clk_i    (clk),
    .rst_ni   (rstN),
    .start_i  (start),
    .flush_i  (flush),
    .op_a_i   (opA),
    .op_b_i   (opB),
    .stall_o  (stall),
    .busy_o   (busy),
    .done_o   (done),
    .product_o(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Start one multiply from IDLE, wait for done, then return to IDLE.
  task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input int expLat, input logic [31:0] expProd);
    int lat;
    logic runOk;
    opA = a;
    opB = b;
    start = 1'b1;
    flush = 1'b0;
    #1;
    checkOutput({tag, " stall c0"}, 64'(stall), 64'd1);
    lat = 0;
    runOk = 1'b1;
    do begin
      stepCycle();
      lat++;
      if (!done && (!stall || !busy)) runOk = 1'b0;
    end while (!done && lat < 40);
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " run stall/busy"}, 64'(runOk), 64'd1);
    checkOutput({tag, " product"}, 64'(product), 64'(expProd));
    checkOutput({tag, " stall at done"}, 64'(stall), 64'd0);
    start = 1'b0;
    stepCycle();
    checkOutput({tag, " done pulse width"}, 64'(done), 64'd0);
    checkOutput({tag, " product held"}, 64'(product), 64'(expProd));
  endtask

  initial begin
    int gap;
    logic heldOk;
    logic noDone;

    rstN  = 1'b0;
    start = 1'b1;
    flush = 1'b0;
    opA   = 16'h0;
    opB   = 16'h0;
    #12;
    checkOutput("reset stall", 64'(stall), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset product", 64'(product), 64'd0);
    start = 1'b0;
    rstN  = 1'b1;
    stepCycle();

    applyStimulus("basic", 16'h1234, 16'h5678, 17, 32'h0626_0060);
    applyStimulus("max", 16'hFFFF, 16'hFFFF, 17, 32'hFFFE_0001);
    applyStimulus("zero", 16'h0000, 16'hABCD, LAT_ZERO, 32'h0000_0000);
    applyStimulus("early", 16'h0003, 16'h0010, LAT_3, 32'h0000_0030);

    // Back-to-back: start stays high so the second multiply begins right after DONE.
    opA = 16'd2;
    opB = 16'd3;
    start = 1'b1;
    gap = 0;
    do begin
      stepCycle();
      gap++;
    end while (!done && gap < 40);
    checkOutput("b2b first latency", 64'(gap), 64'(LAT_2));
    checkOutput("b2b first product", 64'(product), 64'h6);
    opA = 16'd5;
    opB = 16'd7;
    gap = 0;
    heldOk = 1'b1;
    do begin
      stepCycle();
      gap++;
      if (!done && product !== 32'h6) heldOk = 1'b0;
    end while (!done && gap < 40);
    checkOutput("b2b done spacing", 64'(gap), 64'(LAT_5 + 1));
    checkOutput("b2b product held", 64'(heldOk), 64'd1);
    checkOutput("b2b second product", 64'(product), 64'h23);
    start = 1'b0;
    stepCycle();

    // Flush at cycle 5 of a long multiply.
    applyStimulus("pre-flush", 16'd2, 16'd3, LAT_2, 32'h6);
    opA = 16'h1234;
    opB = 16'h5678;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) stepCycle();
    checkOutput("flush busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    start = 1'b0;
    stepCycle();
    flush = 1'b0;
    #1;
    checkOutput("flush stall", 64'(stall), 64'd0);
    checkOutput("flush busy", 64'(busy), 64'd0);
    noDone = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done) noDone = 1'b0;
      stepCycle();
    end
    checkOutput("flush no done", 64'(noDone), 64'd1);
    checkOutput("flush product", 64'(product), 64'h6);

    // Asynchronous reset at cycle 8 of a run.
    opA = 16'h1234;
    opB = 16'h5678;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) stepCycle();
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    rstN = 1'b0;
    #1;
    checkOutput("mid-run reset stall", 64'(stall), 64'd0);
    checkOutput("mid-run reset busy", 64'(busy), 64'd0);
    checkOutput("mid-run reset done", 64'(done), 64'd0);
    checkOutput("mid-run reset product", 64'(product), 64'd0);
    start = 1'b0;
    stepCycle();
    rstN = 1'b1;
    stepCycle();
    applyStimulus("after reset", 16'd3, 16'd4, LAT_3, 32'hC);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
